// File: rtl/mipi_reg_wr_arb.sv
// mipi_reg_wr_arb: arbitrates register writes from the host bus (req0) and the
// init sequencer (req1) onto a single-cycle write strobe to the MIPI register
// block, with a programmable idle gap after every issued write.
// Optional feature macro: MIPI_WR_ARB_ROUND_ROBIN_EN selects round-robin
// arbitration on simultaneous requests; default build is fixed priority (req0).
module mipi_reg_wr_arb #(
    parameter  int unsigned GAP_CYCLES = 1,
    localparam int unsigned AW = 32,
    localparam int unsigned DW = 32,
    localparam int unsigned CW = 16,
    localparam int unsigned GW = 4
) (
    input  logic          aclk,
    input  logic          areset,
    input  logic          req0_valid,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_data,
    input  logic          req1_valid,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_data,
    output logic          req0_ready,
    output logic          req1_ready,
    output logic          mem_wr_valid,
    output logic [AW-1:0] mem_wr_addr,
    output logic [DW-1:0] mem_wr_data,
    output logic          grant_id,
    output logic          busy,
    output logic [CW-1:0] wr_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
    logic            mem_wr_valid_q, mem_wr_valid_d;
    logic            req0_ready_q, req0_ready_d;
    logic            req1_ready_q, req1_ready_d;
    logic [AW-1:0]   mem_wr_addr_q, mem_wr_addr_d;
    logic [DW-1:0]   mem_wr_data_q, mem_wr_data_d;
    logic            grant_id_q, grant_id_d;
    logic [CW-1:0]   wr_count_q, wr_count_d;
    logic            sel1_c;
`ifdef MIPI_WR_ARB_ROUND_ROBIN_EN
    logic            last_grant_q, last_grant_d;
`endif

    // Winner selection: req1 wins when alone, or on a tie when it is its turn
    always_comb begin
        sel1_c = 1'b0;
`ifdef MIPI_WR_ARB_ROUND_ROBIN_EN
        sel1_c = req1_valid && (!req0_valid || !last_grant_q);
`else
        sel1_c = req1_valid && !req0_valid;
`endif
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d        = state_q;
        gap_cnt_d      = gap_cnt_q;
        mem_wr_valid_d = 1'b0;
        req0_ready_d   = 1'b0;
        req1_ready_d   = 1'b0;
        mem_wr_addr_d  = mem_wr_addr_q;
        mem_wr_data_d  = mem_wr_data_q;
        grant_id_d     = grant_id_q;
        wr_count_d     = wr_count_q;
`ifdef MIPI_WR_ARB_ROUND_ROBIN_EN
        last_grant_d   = last_grant_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req0_valid || req1_valid) begin
                    state_d        = ST_ISSUE;
                    mem_wr_addr_d  = sel1_c ? req1_addr : req0_addr;
                    mem_wr_data_d  = sel1_c ? req1_data : req0_data;
                    grant_id_d     = sel1_c;
                    wr_count_d     = wr_count_q + CW'(1);
                    mem_wr_valid_d = 1'b1;
                    req0_ready_d   = !sel1_c;
                    req1_ready_d   = sel1_c;
`ifdef MIPI_WR_ARB_ROUND_ROBIN_EN
                    last_grant_d   = sel1_c;
`endif
                end
            end
            ST_ISSUE: begin
                if (GAP_CYCLES > 0) begin
                    state_d   = ST_GAP;
                    gap_cnt_d = GW'(GAP_CYCLES);
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_GAP: begin
                // Requests are ignored here; leave once the counter hits 1
                if (gap_cnt_q <= GW'(1)) begin
                    state_d   = ST_IDLE;
                    gap_cnt_d = '0;
                end else begin
                    gap_cnt_d = gap_cnt_q - GW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset wins over everything
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q        <= ST_IDLE;
            gap_cnt_q      <= '0;
            mem_wr_valid_q <= 1'b0;
            req0_ready_q   <= 1'b0;
            req1_ready_q   <= 1'b0;
            mem_wr_addr_q  <= '0;
            mem_wr_data_q  <= '0;
            grant_id_q     <= 1'b0;
            wr_count_q     <= '0;
`ifdef MIPI_WR_ARB_ROUND_ROBIN_EN
            last_grant_q   <= 1'b1;
`endif
        end else begin
            state_q        <= state_d;
            gap_cnt_q      <= gap_cnt_d;
            mem_wr_valid_q <= mem_wr_valid_d;
            req0_ready_q   <= req0_ready_d;
            req1_ready_q   <= req1_ready_d;
            mem_wr_addr_q  <= mem_wr_addr_d;
            mem_wr_data_q  <= mem_wr_data_d;
            grant_id_q     <= grant_id_d;
            wr_count_q     <= wr_count_d;
`ifdef MIPI_WR_ARB_ROUND_ROBIN_EN
            last_grant_q   <= last_grant_d;
`endif
        end
    end

    assign mem_wr_valid = mem_wr_valid_q;
    assign req0_ready   = req0_ready_q;
    assign req1_ready   = req1_ready_q;
    assign mem_wr_addr  = mem_wr_addr_q;
    assign mem_wr_data  = mem_wr_data_q;
    assign grant_id     = grant_id_q;
    assign busy         = (state_q != ST_IDLE);
    assign wr_count     = wr_count_q;

endmodule

// File: tb/tb_mipi_reg_wr_arb.sv
// tb_mipi_reg_wr_arb: three arbiters (GAP_CYCLES = 1, 0, 3) share one stimulus
// stream and are checked against a transaction-level model that only tracks
// when each arbiter may next accept a request.
module tb_mipi_reg_wr_arb;

    localparam int unsigned N = 3;
    localparam int unsigned GAPS [N] = '{1, 0, 3};

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic        v0 = 1'b0, v1 = 1'b0;
    logic [31:0] a0 = '0, a1 = '0, dt0 = '0, dt1 = '0;

    logic        d_valid [N];
    logic        d_r0    [N];
    logic        d_r1    [N];
    logic [31:0] d_addr  [N];
    logic [31:0] d_data  [N];
    logic        d_gid   [N];
    logic        d_busy  [N];
    logic [15:0] d_cnt   [N];

    // Model state / expectations
    logic        e_valid [N];
    logic        e_r0    [N];
    logic        e_r1    [N];
    logic [31:0] e_addr  [N];
    logic [31:0] e_data  [N];
    logic        e_gid   [N];
    logic        e_busy  [N];
    logic [15:0] e_cnt   [N];
    logic        m_last  [N];
    int          m_free  [N];
    int          cyc = 0;

    int total = 0;
    int bad = 0;

    always #5 aclk = ~aclk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        mipi_reg_wr_arb #(.GAP_CYCLES(GAPS[g])) dut (
            .aclk        (aclk),
            .areset      (areset),
            .req0_valid  (v0),
            .req0_addr   (a0),
            .req0_data   (dt0),
            .req1_valid  (v1),
            .req1_addr   (a1),
            .req1_data   (dt1),
            .req0_ready  (d_r0[g]),
            .req1_ready  (d_r1[g]),
            .mem_wr_valid(d_valid[g]),
            .mem_wr_addr (d_addr[g]),
            .mem_wr_data (d_data[g]),
            .grant_id    (d_gid[g]),
            .busy        (d_busy[g]),
            .wr_count    (d_cnt[g])
        );
    end

    // Advance one clock, update the model from the inputs seen at that edge
    task automatic tick();
        logic win;
        @(posedge aclk);
        for (int i = 0; i < N; i++) begin
            e_valid[i] = 1'b0;
            e_r0[i]    = 1'b0;
            e_r1[i]    = 1'b0;
            if (areset) begin
                m_free[i] = cyc + 1;
                e_addr[i] = '0;
                e_data[i] = '0;
                e_gid[i]  = 1'b0;
                e_cnt[i]  = '0;
                m_last[i] = 1'b1;
            end else if (cyc >= m_free[i] && (v0 || v1)) begin
`ifdef MIPI_WR_ARB_ROUND_ROBIN_EN
                win = (v0 && v1) ? !m_last[i] : v1;
`else
                win = !v0;
`endif
                e_addr[i]  = win ? a1 : a0;
                e_data[i]  = win ? dt1 : dt0;
                e_gid[i]   = win;
                e_cnt[i]   = e_cnt[i] + 16'd1;
                e_valid[i] = 1'b1;
                e_r0[i]    = !win;
                e_r1[i]    = win;
                m_last[i]  = win;
                m_free[i]  = cyc + 2 + int'(GAPS[i]);
            end
            e_busy[i] = (cyc + 1 < m_free[i]);
        end
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        areset = 1'b1; v0 = 1'b0; v1 = 1'b0;
        tick(); tick();
        for (int i = 0; i < N; i++) begin
            total += 8;
            if (d_valid[i] !== 1'b0) begin bad++; $display("FAIL reset_valid inst%0d got %b want 0", i, d_valid[i]); end
            if (d_r0[i] !== 1'b0)    begin bad++; $display("FAIL reset_r0 inst%0d got %b want 0", i, d_r0[i]); end
            if (d_r1[i] !== 1'b0)    begin bad++; $display("FAIL reset_r1 inst%0d got %b want 0", i, d_r1[i]); end
            if (d_addr[i] !== 32'h0) begin bad++; $display("FAIL reset_addr inst%0d got %h want 0", i, d_addr[i]); end
            if (d_data[i] !== 32'h0) begin bad++; $display("FAIL reset_data inst%0d got %h want 0", i, d_data[i]); end
            if (d_gid[i] !== 1'b0)   begin bad++; $display("FAIL reset_gid inst%0d got %b want 0", i, d_gid[i]); end
            if (d_busy[i] !== 1'b0)  begin bad++; $display("FAIL reset_busy inst%0d got %b want 0", i, d_busy[i]); end
            if (d_cnt[i] !== 16'h0)  begin bad++; $display("FAIL reset_cnt inst%0d got %h want 0", i, d_cnt[i]); end
        end
        areset = 1'b0;
        tick();
    endtask

    task automatic test_single();
        int busy_n;
        v0 = 1'b1; a0 = 32'h0; dt0 = 32'h1;
        tick();
        v0 = 1'b0;
        total += 7;
        if (d_valid[0] !== 1'b1)  begin bad++; $display("FAIL single_valid got %b want 1", d_valid[0]); end
        if (d_r0[0] !== 1'b1)     begin bad++; $display("FAIL single_r0 got %b want 1", d_r0[0]); end
        if (d_r1[0] !== 1'b0)     begin bad++; $display("FAIL single_r1 got %b want 0", d_r1[0]); end
        if (d_addr[0] !== 32'h0)  begin bad++; $display("FAIL single_addr got %h want 0", d_addr[0]); end
        if (d_data[0] !== 32'h1)  begin bad++; $display("FAIL single_data got %h want 1", d_data[0]); end
        if (d_gid[0] !== 1'b0)    begin bad++; $display("FAIL single_gid got %b want 0", d_gid[0]); end
        if (d_cnt[0] !== 16'h1)   begin bad++; $display("FAIL single_cnt got %h want 1", d_cnt[0]); end
        busy_n = int'(d_busy[0]);
        for (int k = 0; k < 5; k++) begin
            tick();
            busy_n += int'(d_busy[0]);
            total++;
            if (d_valid[0] !== 1'b0) begin bad++; $display("FAIL single_extra_strobe got %b want 0", d_valid[0]); end
        end
        total++;
        if (busy_n != 2) begin bad++; $display("FAIL single_busy_cycles got %0d want 2", busy_n); end
    endtask

    task automatic test_arb_order();
        logic got [4];
        int   n = 0;
        logic r1_seen = 1'b0;
        areset = 1'b1; tick(); areset = 1'b0;
        v0 = 1'b1; v1 = 1'b1; a0 = 32'h100; a1 = 32'h200;
        for (int k = 0; k < 40 && n < 4; k++) begin
            tick();
            if (d_r1[0]) r1_seen = 1'b1;
            if (d_valid[0]) begin
                got[n] = d_gid[0];
                total++;
                if (d_addr[0] !== (d_gid[0] ? 32'h200 : 32'h100)) begin
                    bad++; $display("FAIL arb_addr n%0d got %h gid %b", n, d_addr[0], d_gid[0]);
                end
                n++;
            end
        end
        v0 = 1'b0; v1 = 1'b0;
        total++;
        if (n != 4) begin bad++; $display("FAIL arb_count got %0d want 4", n); end
        for (int k = 0; k < n; k++) begin
            total++;
`ifdef MIPI_WR_ARB_ROUND_ROBIN_EN
            if (got[k] !== 1'(k % 2)) begin bad++; $display("FAIL arb_order n%0d got %b want %0d", k, got[k], k % 2); end
`else
            if (got[k] !== 1'b0) begin bad++; $display("FAIL arb_order n%0d got %b want 0", k, got[k]); end
`endif
        end
`ifndef MIPI_WR_ARB_ROUND_ROBIN_EN
        total++;
        if (r1_seen !== 1'b0) begin bad++; $display("FAIL arb_r1_ready got %b want 0", r1_seen); end
`endif
    endtask

    task automatic test_throughput();
        int last [N];
        int seen [N];
        areset = 1'b1; tick(); areset = 1'b0;
        for (int i = 0; i < N; i++) begin last[i] = -1; seen[i] = 0; end
        v1 = 1'b1; a1 = 32'h55; dt1 = 32'h66;
        for (int k = 0; k < 40; k++) begin
            tick();
            for (int i = 0; i < N; i++) begin
                if (d_valid[i]) begin
                    total++;
                    if (d_r1[i] !== 1'b1 || d_r0[i] !== 1'b0 || d_gid[i] !== 1'b1) begin
                        bad++; $display("FAIL tput_grant inst%0d r1 %b r0 %b gid %b want 1 0 1", i, d_r1[i], d_r0[i], d_gid[i]);
                    end
                    if (last[i] >= 0 && seen[i] < 4) begin
                        total++;
                        if (k - last[i] != 2 + int'(GAPS[i])) begin
                            bad++; $display("FAIL tput_period inst%0d got %0d want %0d", i, k - last[i], 2 + int'(GAPS[i]));
                        end
                        seen[i]++;
                    end
                    last[i] = k;
                end
            end
        end
        v1 = 1'b0;
        for (int i = 0; i < N; i++) begin
            total++;
            if (seen[i] < 4) begin bad++; $display("FAIL tput_samples inst%0d got %0d want 4", i, seen[i]); end
        end
    endtask

    task automatic test_reset_in_issue();
        areset = 1'b1; tick(); areset = 1'b0;
        v0 = 1'b1; a0 = 32'h10; dt0 = 32'h20;
        tick();
        for (int i = 0; i < N; i++) begin
            total++;
            if (d_valid[i] !== 1'b1) begin bad++; $display("FAIL rii_issue inst%0d got %b want 1", i, d_valid[i]); end
        end
        areset = 1'b1;
        tick();
        areset = 1'b0;
        for (int i = 0; i < N; i++) begin
            total += 3;
            if (d_valid[i] !== 1'b0) begin bad++; $display("FAIL rii_valid inst%0d got %b want 0", i, d_valid[i]); end
            if (d_busy[i] !== 1'b0)  begin bad++; $display("FAIL rii_busy inst%0d got %b want 0", i, d_busy[i]); end
            if (d_cnt[i] !== 16'h0)  begin bad++; $display("FAIL rii_cnt inst%0d got %h want 0", i, d_cnt[i]); end
        end
        tick();
        v0 = 1'b0;
        for (int i = 0; i < N; i++) begin
            total += 2;
            if (d_valid[i] !== 1'b1) begin bad++; $display("FAIL rii_reissue inst%0d got %b want 1", i, d_valid[i]); end
            if (d_cnt[i] !== 16'h1)  begin bad++; $display("FAIL rii_cnt1 inst%0d got %h want 1", i, d_cnt[i]); end
        end
    endtask

    task automatic test_addr_change();
        int n = 0;
        areset = 1'b1; tick(); areset = 1'b0;
        v0 = 1'b1; a0 = 32'h4; dt0 = 32'hAA;
        tick();
        total += 2;
        if (d_valid[0] !== 1'b1) begin bad++; $display("FAIL ach_first_valid got %b want 1", d_valid[0]); end
        if (d_addr[0] !== 32'h4) begin bad++; $display("FAIL ach_first_addr got %h want 4", d_addr[0]); end
        tick();
        a0 = 32'h8; dt0 = 32'hBB;
        for (int k = 0; k < 10 && n == 0; k++) begin
            tick();
            if (d_valid[0]) begin
                n++;
                total += 2;
                if (d_addr[0] !== 32'h8)  begin bad++; $display("FAIL ach_second_addr got %h want 8", d_addr[0]); end
                if (d_data[0] !== 32'hBB) begin bad++; $display("FAIL ach_second_data got %h want bb", d_data[0]); end
            end
        end
        v0 = 1'b0;
        total++;
        if (n != 1) begin bad++; $display("FAIL ach_second_write got %0d want 1", n); end
    endtask

    task automatic test_wrap();
        int n = 0;
        areset = 1'b1; tick(); areset = 1'b0;
        tick();
        g_dut[0].dut.wr_count_q = 16'hFFFE;
        e_cnt[0] = 16'hFFFE;
        v0 = 1'b1; a0 = 32'h30; dt0 = 32'h40;
        for (int k = 0; k < 20 && n < 2; k++) begin
            tick();
            if (d_valid[0]) begin
                total += 2;
                if (d_cnt[0] !== (n == 0 ? 16'hFFFF : 16'h0000)) begin
                    bad++; $display("FAIL wrap_cnt n%0d got %h want %h", n, d_cnt[0], (n == 0 ? 16'hFFFF : 16'h0000));
                end
                if (d_r0[0] !== 1'b1) begin bad++; $display("FAIL wrap_ready n%0d got %b want 1", n, d_r0[0]); end
                n++;
            end
        end
        v0 = 1'b0;
        tick();
        total += 2;
        if (n != 2) begin bad++; $display("FAIL wrap_writes got %0d want 2", n); end
        if (d_valid[0] !== 1'b0) begin bad++; $display("FAIL wrap_pulse_width got %b want 0", d_valid[0]); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            areset = ($urandom_range(0, 49) == 0);
            v0  = ($urandom_range(0, 2) != 0);
            v1  = ($urandom_range(0, 2) != 0);
            a0  = $urandom(); a1 = $urandom();
            dt0 = $urandom(); dt1 = $urandom();
            tick();
            for (int i = 0; i < N; i++) begin
                total += 8;
                if (d_valid[i] !== e_valid[i]) begin bad++; $display("FAIL rnd_valid inst%0d cyc%0d got %b want %b", i, cyc, d_valid[i], e_valid[i]); end
                if (d_r0[i] !== e_r0[i])       begin bad++; $display("FAIL rnd_r0 inst%0d cyc%0d got %b want %b", i, cyc, d_r0[i], e_r0[i]); end
                if (d_r1[i] !== e_r1[i])       begin bad++; $display("FAIL rnd_r1 inst%0d cyc%0d got %b want %b", i, cyc, d_r1[i], e_r1[i]); end
                if (d_addr[i] !== e_addr[i])   begin bad++; $display("FAIL rnd_addr inst%0d cyc%0d got %h want %h", i, cyc, d_addr[i], e_addr[i]); end
                if (d_data[i] !== e_data[i])   begin bad++; $display("FAIL rnd_data inst%0d cyc%0d got %h want %h", i, cyc, d_data[i], e_data[i]); end
                if (d_gid[i] !== e_gid[i])     begin bad++; $display("FAIL rnd_gid inst%0d cyc%0d got %b want %b", i, cyc, d_gid[i], e_gid[i]); end
                if (d_busy[i] !== e_busy[i])   begin bad++; $display("FAIL rnd_busy inst%0d cyc%0d got %b want %b", i, cyc, d_busy[i], e_busy[i]); end
                if (d_cnt[i] !== e_cnt[i])     begin bad++; $display("FAIL rnd_cnt inst%0d cyc%0d got %h want %h", i, cyc, d_cnt[i], e_cnt[i]); end
            end
        end
        areset = 1'b0; v0 = 1'b0; v1 = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            m_free[i] = 0; m_last[i] = 1'b1; e_cnt[i] = '0;
            e_addr[i] = '0; e_data[i] = '0; e_gid[i] = 1'b0;
        end
        test_reset();
        test_single();
        test_arb_order();
        test_throughput();
        test_reset_in_issue();
        test_addr_change();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
